encode_packer: RTL and testbench

ENCODE_PACKER -- requirements
Module: encode_packer

---
 rtl/encode_packer_pkg.sv | 15 +
 rtl/encode_packer_if.sv | 27 ++
 rtl/encode_packer.sv | 97 +++++++++
 tb/tb_encode_packer.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/encode_packer_pkg.sv
// Shared types and helpers for the encode_packer bit packer.
package encode_pkg;

  // Two-state packer control: RUN accepts groups, FLUSH drains the tail.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Width of a counter able to hold every value from 0 to buf_w inclusive.
  function automatic int cnt_w(input int buf_w);
    return $clog2(buf_w + 1);
  endfunction

endpackage

// File: rtl/encode_packer_if.sv
// Input-group stream and output-word stream of the packer.
// Handshake: a beat transfers on a rising clk edge where valid and ready are
// both high; valid and its payload hold until that edge, and ready never
// depends combinationally on the same-side valid.
interface encode_packer_if #(
  parameter int IN_W  = 24,
  parameter int OUT_W = 32
);
  logic [IN_W-1:0]  din;
  logic             din_valid;
  logic             din_last;
  logic             din_ready;
  logic [OUT_W-1:0] dout;
  logic             dout_valid;
  logic             dout_last;
  logic             dout_ready;

  modport slave (
    input  din, din_valid, din_last, dout_ready,
    output din_ready, dout, dout_valid, dout_last
  );

  modport master (
    output din, din_valid, din_last, dout_ready,
    input  din_ready, dout, dout_valid, dout_last
  );
endinterface

// File: rtl/encode_packer.sv
// Packs IN_W-bit LSB-first groups into OUT_W-bit words; the last group of a
// message flushes the buffer, zero-padding the final partial word.
module encode_packer
  import encode_pkg::*;
#(
  parameter int IN_W  = 24,
  parameter int OUT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  encode_packer_if.slave    bus,
  output state_e            state_dbg
);

  localparam int BUF_W = IN_W + OUT_W;
  localparam int CNT_W = cnt_w(BUF_W);
  localparam logic [CNT_W-1:0] OUT_C = CNT_W'(OUT_W);
  localparam logic [CNT_W-1:0] IN_C  = CNT_W'(IN_W);

  state_e           state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] fill_q, fill_d;

  logic             din_ready;
  logic             dout_valid;
  logic             dout_last;
  logic             in_xfer;
  logic             out_xfer;
  logic [BUF_W-1:0] buf_s;
  logic [CNT_W-1:0] fill_s;

  // Handshake flags come only from state and fill, so no input reaches them.
  always_comb begin
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    dout_last  = 1'b0;
    case (state_q)
      RUN: begin
        din_ready  = (fill_q <= OUT_C);
        dout_valid = (fill_q >= OUT_C);
      end
      FLUSH: begin
        dout_valid = (fill_q != '0);
        dout_last  = (fill_q != '0) && (fill_q <= OUT_C);
      end
      default: ;
    endcase
  end

  assign bus.din_ready  = din_ready;
  assign bus.dout_valid = dout_valid;
  assign bus.dout_last  = dout_last;
  assign bus.dout       = buf_q[OUT_W-1:0];
  assign state_dbg      = state_q;

  // Next buffer/fill/state: drain a word first, then append the new group
  // at the post-drain fill position.
  always_comb begin
    in_xfer  = bus.din_valid && din_ready;
    out_xfer = dout_valid && bus.dout_ready;
    buf_s    = buf_q;
    fill_s   = fill_q;
    if (out_xfer) begin
      if (dout_last) begin
        // Final (possibly padded) word leaves the buffer empty.
        buf_s  = '0;
        fill_s = '0;
      end else begin
        buf_s  = buf_q >> OUT_W;
        fill_s = fill_q - OUT_C;
      end
    end
    buf_d   = buf_s;
    fill_d  = fill_s;
    state_d = state_q;
    if (in_xfer) begin
      buf_d  = buf_s | (BUF_W'(bus.din) << fill_s);
      fill_d = fill_s + IN_C;
      if (bus.din_last) state_d = FLUSH;
    end
    if ((state_q == FLUSH) && out_xfer && dout_last) state_d = RUN;
  end

  // State, buffer and fill registers; reset discards any buffered bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      buf_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      fill_q  <= fill_d;
    end
  end

endmodule

// File: tb/tb_encode_packer.sv
// Bench for encode_packer: directed cases plus randomized throttled messages
// checked by a bit-level reference model and an output scoreboard.
module tb_encode_packer;
  import encode_pkg::*;

  localparam int IN_W   = 24;
  localparam int OUT_W  = 32;
  localparam int IN_WB  = 12;
  localparam int OUT_WB = 8;

  logic clk;
  logic rst;
  logic rst_b;
  state_e state_a;
  state_e state_b;

  encode_packer_if #(.IN_W(IN_W),  .OUT_W(OUT_W))  bus();
  encode_packer_if #(.IN_W(IN_WB), .OUT_W(OUT_WB)) bus_b();

  encode_packer #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .state_dbg(state_a)
  );

  encode_packer #(.IN_W(IN_WB), .OUT_W(OUT_WB)) dut_b (
    .clk(clk), .rst(rst_b), .bus(bus_b.slave), .state_dbg(state_b)
  );

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- bookkeeping ----------------
  int total = 0;
  int bad   = 0;
  logic [OUT_W:0]  exp_q[$];
  logic [OUT_WB:0] exp_qb[$];
  logic [IN_W-1:0] msg_q[$];
  int words_seen = 0;
  int rdy_pct    = 100;
  int gap_pct    = 0;
  int stall_at   = -1;
  logic [OUT_W-1:0] stall_exp = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s: got timeout expected progress", name);
  endtask

  // ---------------- reference model ----------------
  // Message bits laid end to end LSB-first, padded to a word boundary and cut
  // into words; the final word carries the last flag.
  task automatic model_push();
    bit bits[$];
    int nw;
    logic [OUT_W-1:0] w;
    foreach (msg_q[i])
      for (int b = 0; b < IN_W; b++) bits.push_back(msg_q[i][b]);
    while ((bits.size() % OUT_W) != 0) bits.push_back(1'b0);
    nw = bits.size() / OUT_W;
    for (int k = 0; k < nw; k++) begin
      for (int j = 0; j < OUT_W; j++) w[j] = bits[k*OUT_W + j];
      exp_q.push_back({(k == nw - 1), w});
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send_beat(input logic [IN_W-1:0] d, input logic l);
    int n;
    while ($urandom_range(99) < gap_pct) begin
      bus.din_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.din       = d;
    bus.din_last  = l;
    bus.din_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.din_ready) break;
      n++;
      if (n > 2000) begin
        fail_now("din_accept");
        break;
      end
    end
    @(posedge clk); #1;
    bus.din_valid = 1'b0;
    bus.din_last  = 1'b0;
  endtask

  task automatic send_msg(input logic check);
    if (check) model_push();
    foreach (msg_q[i]) send_beat(msg_q[i], (i == msg_q.size() - 1) && check);
  endtask

  task automatic send_b(input logic [IN_WB-1:0] d, input logic l);
    int n;
    bus_b.din       = d;
    bus_b.din_last  = l;
    bus_b.din_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (bus_b.din_ready) break;
      n++;
      if (n > 200) begin
        fail_now("din_accept_b");
        break;
      end
    end
    @(posedge clk); #1;
    bus_b.din_valid = 1'b0;
    bus_b.din_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  // dout_ready driver: random throttle, plus a one-shot 5-cycle stall on a
  // chosen word index.
  initial begin
    bus.dout_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (stall_at >= 0 && words_seen == stall_at && bus.dout_valid) begin
        for (int s = 0; s < 5; s++) begin
          bus.dout_ready = 1'b0;
          @(negedge clk);
          chk("stall_word", bus.dout, stall_exp);
          chk("stall_din_ready", bus.din_ready, 0);
          @(posedge clk); #1;
        end
        stall_at = -1;
        bus.dout_ready = 1'b1;
      end else begin
        bus.dout_ready = ($urandom_range(99) < rdy_pct);
      end
    end
  end

  // ---------------- scoreboard monitors ----------------
  logic              hold_pend = 1'b0;
  logic [OUT_W+1:0]  hold_val  = '0;

  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend)
        chk("hold", {bus.dout_valid, bus.dout_last, bus.dout}, hold_val);
      if (bus.dout_valid && bus.dout_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL word_unexpected: got 0x%0h last=%0d expected none",
                   bus.dout, bus.dout_last);
        end else begin
          chk("word", {bus.dout_last, bus.dout}, exp_q.pop_front());
        end
        words_seen++;
      end
      hold_pend = bus.dout_valid && !bus.dout_ready;
      hold_val  = {1'b1, bus.dout_last, bus.dout};
    end
  end

  always @(negedge clk) begin
    if (!rst_b && bus_b.dout_valid && bus_b.dout_ready) begin
      if (exp_qb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL word_b_unexpected: got 0x%0h expected none", bus_b.dout);
      end else begin
        chk("word_b", {bus_b.dout_last, bus_b.dout}, exp_qb.pop_front());
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int len;
    rst   = 1'b1;
    rst_b = 1'b1;
    bus.din = '0;   bus.din_valid = 1'b0;   bus.din_last = 1'b0;
    bus_b.din = '0; bus_b.din_valid = 1'b0; bus_b.din_last = 1'b0;
    bus_b.dout_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dout",       bus.dout, 0);
    chk("rst_dout_valid", bus.dout_valid, 0);
    chk("rst_dout_last",  bus.dout_last, 0);
    chk("rst_din_ready",  bus.din_ready, 1);
    chk("rst_state",      state_a, RUN);
    rst   = 1'b0;
    rst_b = 1'b0;
    @(posedge clk); #1;

    // Narrow-config case: 12-bit groups into 8-bit words.
    exp_qb.push_back({1'b0, 8'hBC});
    exp_qb.push_back({1'b0, 8'h3A});
    exp_qb.push_back({1'b1, 8'h12});
    send_b(12'hABC, 1'b0);
    send_b(12'h123, 1'b1);
    n = 0;
    while (exp_qb.size() != 0 && n < 100) begin @(posedge clk); n++; end
    #1;
    chk("drain_b_left", exp_qb.size(), 0);
    chk("b_state_run", state_b, RUN);

    // Four groups, three words, last on the third.
    rdy_pct = 100;
    msg_q = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
    send_msg(1'b1);
    wait_drain();

    // Single-group message, then idle in RUN ready for more.
    msg_q = '{24'hABCDEF};
    send_msg(1'b1);
    wait_drain();
    chk("single_state", state_a, RUN);
    chk("single_din_ready", bus.din_ready, 1);
    chk("single_dout_valid", bus.dout_valid, 0);

    // Same four groups with a 5-cycle backpressure stall on the second word.
    stall_at  = words_seen + 1;
    stall_exp = 32'h33332222;
    msg_q = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
    send_msg(1'b1);
    wait_drain();

    // Reset in the middle of a message discards the buffered bits.
    rdy_pct = 0;
    @(posedge clk); #1;
    msg_q = '{24'h111111, 24'h222222};
    send_msg(1'b0);
    chk("pre_rst_valid", bus.dout_valid, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_dout",       bus.dout, 0);
    chk("mid_rst_dout_valid", bus.dout_valid, 0);
    chk("mid_rst_dout_last",  bus.dout_last, 0);
    chk("mid_rst_din_ready",  bus.din_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rdy_pct = 100;
    @(posedge clk); #1;
    msg_q = '{24'h555555};
    send_msg(1'b1);
    wait_drain();

    // Randomized messages with random valid gaps and ready throttling.
    for (int m = 0; m < 1000; m++) begin
      rdy_pct = $urandom_range(30, 100);
      gap_pct = $urandom_range(0, 50);
      len = $urandom_range(1, 6);
      msg_q.delete();
      for (int b = 0; b < len; b++) msg_q.push_back(IN_W'($urandom));
      send_msg(1'b1);
    end
    rdy_pct = 100;
    wait_drain();
    chk("final_state", state_a, RUN);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
